// File: rtl/vga_driver.sv
// VGA timing generator: free-running pixel/line counters, sync pulses, a pixel
// request one cycle ahead of the active window, and a per-frame start pulse.
module vga_driver #(
  parameter logic [9:0] H_SYNC  = 10'd96,
  parameter logic [9:0] H_BACK  = 10'd48,
  parameter logic [9:0] H_DISP  = 10'd640,
  parameter logic [9:0] H_FRONT = 10'd16,
  parameter logic [9:0] H_TOTAL = 10'd800,
  parameter logic [9:0] V_SYNC  = 10'd2,
  parameter logic [9:0] V_BACK  = 10'd33,
  parameter logic [9:0] V_DISP  = 10'd480,
  parameter logic [9:0] V_FRONT = 10'd10,
  parameter logic [9:0] V_TOTAL = 10'd525
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic        data_req,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        video_en,
  output logic [23:0] vga_rgb,
  output logic        frame_start
);

  // Window bounds are 11 bits wide so sums of 10-bit parameters cannot wrap.
  localparam logic [10:0] HActBeg = 11'(H_SYNC) + 11'(H_BACK);
  localparam logic [10:0] HActEnd = HActBeg + 11'(H_DISP);
  localparam logic [10:0] HReqBeg = HActBeg - 11'd1;
  localparam logic [10:0] HReqEnd = HActEnd - 11'd1;
  localparam logic [10:0] VActBeg = 11'(V_SYNC) + 11'(V_BACK);
  localparam logic [10:0] VActEnd = VActBeg + 11'(V_DISP);
  localparam logic [9:0]  HReqOff = 10'(HReqBeg);
  localparam logic [9:0]  VActOff = 10'(VActBeg);
  // A total of 1024 reads as 0 in ten bits; subtracting one still yields 1023.
  localparam logic [9:0]  HLast   = H_TOTAL - 10'd1;
  localparam logic [9:0]  VLast   = V_TOTAL - 10'd1;

  logic [9:0]  cnt_h_q, cnt_h_d;
  logic [9:0]  cnt_v_q, cnt_v_d;
  logic        frame_start_q, frame_start_d;
  logic        line_end, frame_end;
  logic [10:0] cnt_h_x, cnt_v_x;
  logic        h_act, h_req, v_act;

  always_comb begin
    line_end      = (cnt_h_q == HLast);
    frame_end     = line_end && (cnt_v_q == VLast);
    cnt_h_d       = line_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d       = cnt_v_q;
    if (line_end) begin
      cnt_v_d = (cnt_v_q == VLast) ? 10'd0 : cnt_v_q + 10'd1;
    end
    frame_start_d = frame_end;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cnt_h_q       <= 10'd0;
      cnt_v_q       <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    cnt_h_x     = {1'b0, cnt_h_q};
    cnt_v_x     = {1'b0, cnt_v_q};
    h_act       = (cnt_h_x >= HActBeg) && (cnt_h_x < HActEnd);
    h_req       = (cnt_h_x >= HReqBeg) && (cnt_h_x < HReqEnd);
    v_act       = (cnt_v_x >= VActBeg) && (cnt_v_x < VActEnd);

    vga_hs      = (cnt_h_q >= H_SYNC);
    vga_vs      = (cnt_v_q >= V_SYNC);
    video_en    = h_act && v_act;
    data_req    = h_req && v_act;
    pixel_xpos  = data_req ? (cnt_h_q - HReqOff) : 10'd0;
    pixel_ypos  = data_req ? (cnt_v_q - VActOff) : 10'd0;
    // Blanking is forced black whatever the pixel generator drives.
    vga_rgb     = video_en ? pixel_data : 24'h000000;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_vga_driver.sv
// Scoreboard bench: two drivers (default and reduced timing) are checked every
// cycle against an arithmetic model derived from the elapsed cycle count.
module tb_vga_driver;

  typedef struct packed {
    logic        hs, vs, en, req, fs, t0, wht;
    logic [9:0]  x, y;
    logic [23:0] rgb;
  } exp_t;

  typedef enum int {MRand, MWhite, MLat} mode_t;

  // Reduced timing so full frames fit in a short run.
  localparam int SHS = 4, SHB = 3, SHD = 10, SHF = 2, SHT = 19;
  localparam int SVS = 2, SVB = 3, SVD = 6, SVF = 2, SVT = 13;
  localparam int BFRAME = 800 * 525;
  localparam int SFRAME = SHT * SVT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_b = '0, pix_s = '0;
  logic        req_b, hs_b, vs_b, en_b, fs_b, req_s, hs_s, vs_s, en_s, fs_s;
  logic [9:0]  x_b, y_b, x_s, y_s;
  logic [23:0] rgb_b, rgb_s;

  int    checks = 0, errors = 0;
  mode_t mode = MRand;
  exp_t  qb[$], qs[$];
  int    tb_t = 0, ts_t = 0;
  bit    wb = 0, ws = 0;
  logic [9:0] last_xb = '0, last_yb = '0, last_xs = '0, last_ys = '0;
  int    s_req_cnt = 0, s_white_cnt = 0;
  bit    s_all_white = 0, s_seen = 0;

  always #5 clk = ~clk;

  vga_driver u_big (
    .vga_clk    (clk),
    .sys_rst    (rst),
    .pixel_data (pix_b),
    .data_req   (req_b),
    .pixel_xpos (x_b),
    .pixel_ypos (y_b),
    .vga_hs     (hs_b),
    .vga_vs     (vs_b),
    .video_en   (en_b),
    .vga_rgb    (rgb_b),
    .frame_start(fs_b)
  );

  vga_driver #(
    .H_SYNC (10'(SHS)), .H_BACK (10'(SHB)), .H_DISP (10'(SHD)),
    .H_FRONT(10'(SHF)), .H_TOTAL(10'(SHT)),
    .V_SYNC (10'(SVS)), .V_BACK (10'(SVB)), .V_DISP (10'(SVD)),
    .V_FRONT(10'(SVF)), .V_TOTAL(10'(SVT))
  ) u_small (
    .vga_clk    (clk),
    .sys_rst    (rst),
    .pixel_data (pix_s),
    .data_req   (req_s),
    .pixel_xpos (x_s),
    .pixel_ypos (y_s),
    .vga_hs     (hs_s),
    .vga_vs     (vs_s),
    .video_en   (en_s),
    .vga_rgb    (rgb_s),
    .frame_start(fs_s)
  );

  function automatic void chk(string name, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected outputs from the cycle index t since reset release (or last wrap).
  function automatic exp_t model(int t, bit w, int hs, int hb, int hd, int ht, int vs,
                                 int vb, int vd, mode_t m, logic [23:0] pix);
    exp_t e;
    int h, v;
    bit vwin;
    h     = t % ht;
    v     = t / ht;
    vwin  = (v >= vs + vb) && (v < vs + vb + vd);
    e.hs  = (h >= hs);
    e.vs  = (v >= vs);
    e.en  = vwin && (h >= hs + hb) && (h < hs + hb + hd);
    e.req = vwin && (h >= hs + hb - 1) && (h < hs + hb + hd - 1);
    e.x   = e.req ? 10'(h - (hs + hb - 1)) : 10'd0;
    e.y   = e.req ? 10'(v - (vs + vb)) : 10'd0;
    e.fs  = w && (t == 0);
    e.t0  = (t == 0);
    e.wht = (m == MWhite);
    if (!e.en) e.rgb = 24'h000000;
    else if (m == MLat) e.rgb = {4'h0, 10'(v - (vs + vb)), 10'(h - (hs + hb))};
    else e.rgb = pix;
    return e;
  endfunction

  function automatic logic [23:0] pick(mode_t m, logic [9:0] lx, logic [9:0] ly);
    if (m == MWhite) return 24'hFFFFFF;
    if (m == MLat) return {4'h0, ly, lx};
    return 24'($urandom);
  endfunction

  // One clock: advance the model with the reset value seen at the edge, drive
  // pixel data for the new cycle and queue the expected outputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      tb_t = 0; wb = 0; ts_t = 0; ws = 0;
    end else begin
      tb_t++;
      if (tb_t == BFRAME) begin tb_t = 0; wb = 1; end
      ts_t++;
      if (ts_t == SFRAME) begin ts_t = 0; ws = 1; end
    end
    pix_b = pick(mode, last_xb, last_yb);
    pix_s = pick(mode, last_xs, last_ys);
    qb.push_back(model(tb_t, wb, 96, 48, 640, 800, 2, 33, 480, mode, pix_b));
    qs.push_back(model(ts_t, ws, SHS, SHB, SHD, SHT, SVS, SVB, SVD, mode, pix_s));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("big_hs", 24'(hs_b), 24'(e.hs));
      chk("big_vs", 24'(vs_b), 24'(e.vs));
      chk("big_video_en", 24'(en_b), 24'(e.en));
      chk("big_data_req", 24'(req_b), 24'(e.req));
      chk("big_xpos", 24'(x_b), 24'(e.x));
      chk("big_ypos", 24'(y_b), 24'(e.y));
      chk("big_rgb", rgb_b, e.rgb);
      chk("big_frame_start", 24'(fs_b), 24'(e.fs));
    end
    if (qs.size() > 0) begin
      e = qs.pop_front();
      chk("small_hs", 24'(hs_s), 24'(e.hs));
      chk("small_vs", 24'(vs_s), 24'(e.vs));
      chk("small_video_en", 24'(en_s), 24'(e.en));
      chk("small_data_req", 24'(req_s), 24'(e.req));
      chk("small_xpos", 24'(x_s), 24'(e.x));
      chk("small_ypos", 24'(y_s), 24'(e.y));
      chk("small_rgb", rgb_s, e.rgb);
      chk("small_frame_start", 24'(fs_s), 24'(e.fs));
      if (e.t0) begin
        if (e.fs && s_seen) begin
          chk("small_req_per_frame", 24'(s_req_cnt), 24'(SHD * SVD));
          if (s_all_white) chk("small_white_per_frame", 24'(s_white_cnt), 24'(SHD * SVD));
        end
        s_seen      = 1;
        s_req_cnt   = 0;
        s_white_cnt = 0;
        s_all_white = 1;
      end
      if (req_s) s_req_cnt++;
      if (rgb_s == 24'hFFFFFF) s_white_cnt++;
      if (!e.wht) s_all_white = 0;
    end
    last_xb = x_b; last_yb = y_b;
    last_xs = x_s; last_ys = y_s;
  end

  initial begin
    bit hit;
    rst  = 1'b1;
    mode = MRand;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    for (int i = 0; i < 9000; i++) step();
    mode = MWhite;
    for (int i = 0; i < 9000; i++) step();
    // Downstream model answers each request one cycle later; spans line 35-36
    // of the default-timing driver.
    mode = MLat;
    for (int i = 0; i < 13000; i++) step();
    mode = MRand;
    hit  = 0;
    for (int i = 0; i < 2 * SFRAME && !hit; i++) begin
      step();
      if (ts_t == 7 * SHT + 9) hit = 1;
    end
    chk("mid_frame_reset_point_reached", 24'(hit), 24'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) step();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 24'(qb.size() + qs.size()), 24'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
